// File: rtl/alarm_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock_core
//  Description : Time-of-day counter (24 h hh:mm:ss) with a self-generated
//                1 s tick, N_ALARMS programmable alarm registers and a
//                ring / snooze state machine with automatic ring timeout.
//
//  Ports
//    masCLK      system clock
//    Reset       asynchronous active-high reset
//    set_time    strobe: load set_hour:set_min:00 into the time counter
//    set_alarm   strobe: load set_hour:set_min into alarm[alarm_sel]
//    alarm_sel   alarm index for set_alarm
//    set_hour    hour value 0..23 for set_time / set_alarm
//    set_min     minute value 0..59 for set_time / set_alarm
//    alarm_en    per-alarm enable levels
//    dismiss     strobe: stop ringing / cancel snooze
//    snooze      strobe: postpone ringing by SNOOZE_MIN minutes
//    tick_1s     one-cycle pulse per second
//    hour/min/sec current time
//    ring        alarm sounding
//    ring_id     index of the ringing alarm (holds last value)
//
//  Build option
//    ALARM_SNOOZE_EN : when defined, the SNOOZE state and snooze timer exist.
//                      When undefined, the snooze input is ignored.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_clock_core #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int N_ALARMS   = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5,
    localparam int AW        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                masCLK,
    input  logic                Reset,
    input  logic                set_time,
    input  logic                set_alarm,
    input  logic [AW-1:0]       alarm_sel,
    input  logic [4:0]          set_hour,
    input  logic [5:0]          set_min,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic                dismiss,
    input  logic                snooze,
    output logic                tick_1s,
    output logic [4:0]          hour,
    output logic [5:0]          min,
    output logic [5:0]          sec,
    output logic                ring,
    output logic [AW-1:0]       ring_id
);

    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam int            RTW       = $clog2(RING_SEC + 1);
    localparam logic [RTW-1:0] RING_LOAD = RTW'(RING_SEC);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] ST_SNOOZE = 2'd2;
    localparam int            STW         = $clog2(SNOOZE_MIN * 60 + 1);
    localparam logic [STW-1:0] SNOOZE_LOAD = STW'(SNOOZE_MIN * 60);
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [PW-1:0]  presc_q, presc_d;
    logic [4:0]     hour_q, hour_d;
    logic [5:0]     min_q, min_d;
    logic [5:0]     sec_q, sec_d;
    logic [4:0]     alarm_hour_q [N_ALARMS];
    logic [4:0]     alarm_hour_d [N_ALARMS];
    logic [5:0]     alarm_min_q  [N_ALARMS];
    logic [5:0]     alarm_min_d  [N_ALARMS];
    logic [1:0]     state_q, state_d;
    logic [AW-1:0]  ring_id_q, ring_id_d;
    logic [RTW-1:0] ring_tmr_q, ring_tmr_d;
`ifdef ALARM_SNOOZE_EN
    logic [STW-1:0] snz_tmr_q, snz_tmr_d;
`else
    // snooze and SNOOZE_MIN have no function in this build
    logic [31:0]    unused_snooze_cfg;
    assign unused_snooze_cfg = {snooze, 31'(SNOOZE_MIN)};
`endif

    logic           time_wr;
    logic           alarm_wr;
    logic           top_of_min;
    logic           match_hit;
    logic [AW-1:0]  match_idx;
    logic           ring_alive;

    // Tick is a decode of the prescaler terminal count; it is high for the
    // single cycle before the edge on which the time advances.
    assign tick_1s = (presc_q == PRESC_MAX);

    assign time_wr  = set_time && (set_hour <= 5'd23) && (set_min <= 6'd59);
    assign alarm_wr = set_alarm && (set_hour <= 5'd23) && (set_min <= 6'd59)
                      && (32'(alarm_sel) < 32'(N_ALARMS));

    // ------------------------------------------------------------------
    // Prescaler and time-of-day
    // ------------------------------------------------------------------
    always_comb begin
        presc_d    = tick_1s ? '0 : presc_q + PW'(1);
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        top_of_min = 1'b0;
        // A valid set_time swallows a coincident tick, so no match can
        // be raised from that tick either.
        if (tick_1s && !time_wr) begin
            if (sec_q == 6'd59) begin
                sec_d      = '0;
                top_of_min = 1'b1;
                if (min_q == 6'd59) begin
                    min_d  = '0;
                    hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
                end else begin
                    min_d  = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        if (time_wr) begin
            presc_d = '0;
            hour_d  = set_hour;
            min_d   = set_min;
            sec_d   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Alarm registers
    // ------------------------------------------------------------------
    always_comb begin
        alarm_hour_d = alarm_hour_q;
        alarm_min_d  = alarm_min_q;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (alarm_wr && (alarm_sel == AW'(i))) begin
                alarm_hour_d[i] = set_hour;
                alarm_min_d[i]  = set_min;
            end
        end
    end

    // Match against the next-state time; descending scan leaves the lowest
    // matching index in match_idx.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (top_of_min && alarm_en[i] &&
                (alarm_hour_q[i] == hour_d) && (alarm_min_q[i] == min_d)) begin
                match_hit = 1'b1;
                match_idx = AW'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge masCLK or posedge Reset) begin
        if (Reset) begin
            presc_q    <= '0;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            state_q    <= ST_IDLE;
            ring_id_q  <= '0;
            ring_tmr_q <= '0;
`ifdef ALARM_SNOOZE_EN
            snz_tmr_q  <= '0;
`endif
            for (int i = 0; i < N_ALARMS; i++) begin
                alarm_hour_q[i] <= '0;
                alarm_min_q[i]  <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            state_q    <= state_d;
            ring_id_q  <= ring_id_d;
            ring_tmr_q <= ring_tmr_d;
`ifdef ALARM_SNOOZE_EN
            snz_tmr_q  <= snz_tmr_d;
`endif
            for (int i = 0; i < N_ALARMS; i++) begin
                alarm_hour_q[i] <= alarm_hour_d[i];
                alarm_min_q[i]  <= alarm_min_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and timers
    // ------------------------------------------------------------------
    assign ring_alive = alarm_en[ring_id_q];

    always_comb begin
        state_d    = state_q;
        ring_id_d  = ring_id_q;
        ring_tmr_d = ring_tmr_q;
`ifdef ALARM_SNOOZE_EN
        snz_tmr_d  = snz_tmr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (match_hit) begin
                    state_d    = ST_RING;
                    ring_id_d  = match_idx;
                    ring_tmr_d = RING_LOAD;
                end
            end
            ST_RING: begin
                if (tick_1s) begin
                    ring_tmr_d = ring_tmr_q - RTW'(1);
                end
                // Timeout fires on the tick that would take the timer to 0.
                if (dismiss || !ring_alive || (tick_1s && ring_tmr_q == RTW'(1))) begin
                    state_d = ST_IDLE;
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze) begin
                    state_d   = ST_SNOOZE;
                    snz_tmr_d = SNOOZE_LOAD;
                end
`endif
            end
`ifdef ALARM_SNOOZE_EN
            ST_SNOOZE: begin
                if (tick_1s) begin
                    snz_tmr_d = snz_tmr_q - STW'(1);
                end
                if (dismiss || !ring_alive) begin
                    state_d = ST_IDLE;
                end else if (tick_1s && snz_tmr_q == STW'(1)) begin
                    state_d    = ST_RING;
                    ring_tmr_d = RING_LOAD;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ring = (state_q == ST_RING);
    end

    assign hour    = hour_q;
    assign min     = min_q;
    assign sec     = sec_q;
    assign ring_id = ring_id_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_clock_core
//  Description : Directed self-checking bench for alarm_clock_core with
//                CLK_HZ=10, N_ALARMS=4, RING_SEC=60, SNOOZE_MIN=5.
//                Covers ALARM_SNOOZE_EN in either build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_clock_core;

    localparam int CLK_HZ = 10;

    logic       masCLK = 1'b0;
    logic       Reset  = 1'b1;
    logic       set_time = 1'b0;
    logic       set_alarm = 1'b0;
    logic [1:0] alarm_sel = '0;
    logic [4:0] set_hour = '0;
    logic [5:0] set_min = '0;
    logic [3:0] alarm_en = '0;
    logic       dismiss = 1'b0;
    logic       snooze = 1'b0;
    logic       tick_1s;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       ring;
    logic [1:0] ring_id;

    int n_asserts = 0;
    int n_fail    = 0;
    int n;

    alarm_clock_core #(
        .CLK_HZ     (CLK_HZ),
        .N_ALARMS   (4),
        .RING_SEC   (60),
        .SNOOZE_MIN (5)
    ) dut (
        .masCLK    (masCLK),
        .Reset     (Reset),
        .set_time  (set_time),
        .set_alarm (set_alarm),
        .alarm_sel (alarm_sel),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .alarm_en  (alarm_en),
        .dismiss   (dismiss),
        .snooze    (snooze),
        .tick_1s   (tick_1s),
        .hour      (hour),
        .min       (min),
        .sec       (sec),
        .ring      (ring),
        .ring_id   (ring_id)
    );

    always #5 masCLK = ~masCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, 32'(hour), 32'(h));
        check({tag, "_min"},  32'(min),  32'(m));
        check({tag, "_sec"},  32'(sec),  32'(s));
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge masCLK);
        #1;
    endtask

    task automatic do_set_time(input logic [4:0] h, input logic [5:0] m);
        set_hour = h;
        set_min  = m;
        set_time = 1'b1;
        step();
        set_time = 1'b0;
    endtask

    task automatic do_set_alarm(input logic [1:0] s, input logic [4:0] h, input logic [5:0] m);
        alarm_sel = s;
        set_hour  = h;
        set_min   = m;
        set_alarm = 1'b1;
        step();
        set_alarm = 1'b0;
    endtask

    task automatic wait_ticks(input int cnt);
        bit found;
        for (int t = 0; t < cnt; t++) begin
            found = 1'b0;
            for (int k = 0; k < 2 * CLK_HZ; k++) begin
                if (tick_1s) begin
                    found = 1'b1;
                    step();
                    break;
                end
                step();
            end
            if (!found) begin
                check("tick_timeout", 32'(found), 32'd1);
                return;
            end
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge masCLK);
        #1;
        Reset = 1'b0;
        check_time("reset", 0, 0, 0);
        check("reset_ring",    32'(ring),    32'd0);
        check("reset_ring_id", 32'(ring_id), 32'd0);
        check("reset_tick",    32'(tick_1s), 32'd0);

        // ---------------- midnight rollover ----------------
        do_set_time(5'd23, 6'd59);
        check_time("set_2359", 23, 59, 0);
        wait_ticks(59);
        check_time("t_235959", 23, 59, 59);
        wait_ticks(1);
        check_time("t_000000", 0, 0, 0);

        // ---------------- single alarm, dismiss ----------------
        alarm_en = 4'b0001;
        do_set_alarm(2'd0, 5'd7, 6'd30);
        do_set_time(5'd7, 6'd29);
        wait_ticks(59);
        check("pre_alarm_ring", 32'(ring), 32'd0);
        wait_ticks(1);
        check_time("alarm0_hit", 7, 30, 0);
        check("alarm0_ring",    32'(ring),    32'd1);
        check("alarm0_ring_id", 32'(ring_id), 32'd0);
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        check("dismiss_ring", 32'(ring), 32'd0);

        // ---------------- ring timeout ----------------
        do_set_time(5'd7, 6'd29);
        wait_ticks(60);
        check("to_ring_rise", 32'(ring), 32'd1);
        wait_ticks(59);
        check("to_ring_59", 32'(ring), 32'd1);
        wait_ticks(1);
        check("to_ring_fall", 32'(ring), 32'd0);
        check_time("to_fall_time", 7, 31, 0);

        // ---------------- priority + disable while ringing ----------------
        alarm_en = 4'b1010;
        do_set_alarm(2'd1, 5'd6, 6'd0);
        do_set_alarm(2'd3, 5'd6, 6'd0);
        do_set_time(5'd5, 6'd59);
        wait_ticks(60);
        check("prio_ring",    32'(ring),    32'd1);
        check("prio_ring_id", 32'(ring_id), 32'd1);
        alarm_en = 4'b1000;
        step();
        check("disable_ring", 32'(ring), 32'd0);
        wait_ticks(2);
        check("no_rering",      32'(ring),    32'd0);
        check("ring_id_held",   32'(ring_id), 32'd1);

        // ---------------- snooze ----------------
        alarm_en = 4'b1010;
        do_set_time(5'd5, 6'd59);
        wait_ticks(60);
        check("snz_ring", 32'(ring), 32'd1);
        snooze = 1'b1;
        step();
        snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
        check("snz_ring_off", 32'(ring), 32'd0);
        wait_ticks(299);
        check("snz_299", 32'(ring), 32'd0);
        wait_ticks(1);
        check("snz_rering",    32'(ring),    32'd1);
        check("snz_ring_id",   32'(ring_id), 32'd1);
        check_time("snz_rering_time", 6, 5, 0);
        dismiss = 1'b1;
        snooze  = 1'b1;
        step();
        dismiss = 1'b0;
        snooze  = 1'b0;
        check("dis_snz_ring", 32'(ring), 32'd0);
        wait_ticks(300);
        check("dis_snz_idle", 32'(ring), 32'd0);
`else
        check("nosnz_ring_stays", 32'(ring), 32'd1);
        wait_ticks(1);
        check("nosnz_ring_tick", 32'(ring), 32'd1);
        dismiss = 1'b1;
        step();
        dismiss = 1'b0;
        check("nosnz_dismiss", 32'(ring), 32'd0);
`endif

        // ---------------- out-of-range set values ----------------
        do_set_time(5'd10, 6'd0);
        do_set_time(5'd24, 6'd5);
        check_time("bad_hour", 10, 0, 0);
        do_set_time(5'd11, 6'd60);
        check_time("bad_min", 10, 0, 0);

        alarm_en = 4'b0100;
        do_set_alarm(2'd2, 5'd8, 6'd0);
        do_set_alarm(2'd2, 5'd24, 6'd0);
        do_set_alarm(2'd2, 5'd9, 6'd60);
        do_set_time(5'd7, 6'd59);
        wait_ticks(60);
        check("alarm2_ring",    32'(ring),    32'd1);
        check("alarm2_ring_id", 32'(ring_id), 32'd2);

        // ---------------- reset mid-ring / mid-count ----------------
        wait_ticks(3);
        Reset = 1'b1;
        #1;
        check("rst_ring",    32'(ring),    32'd0);
        check("rst_ring_id", 32'(ring_id), 32'd0);
        check_time("rst_time", 0, 0, 0);
        step();
        Reset = 1'b0;
        n = 0;
        while (sec != 6'd1 && n < 40) begin
            step();
            n++;
        end
        check("first_tick_cycles", 32'(n), 32'd10);
        n = 0;
        while (sec != 6'd2 && n < 40) begin
            step();
            n++;
        end
        check("tick_spacing", 32'(n), 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
